// File: rtl/match_event_logger_pkg.sv
// Shared default constants for the match event logger slice.
package match_event_pkg;

    localparam int TS_WIDTH_DEF  = 16;
    localparam int DEPTH_DEF     = 4;
    localparam int CNT_WIDTH_DEF = 8;

endpackage

// File: rtl/match_event_logger_if.sv
// Event stream handshake between the logger (master) and its consumer (slave).
interface match_event_logger_if
    import match_event_pkg::*;
#(
    parameter int TS_WIDTH = TS_WIDTH_DEF
);

    logic                evt_valid;
    logic                evt_ready;
    logic [TS_WIDTH-1:0] evt_ts;

    modport master (output evt_valid, output evt_ts, input evt_ready);
    modport slave  (input evt_valid, input evt_ts, output evt_ready);

endinterface

// File: rtl/match_event_logger_event_fifo.sv
// First-word-fall-through FIFO holding captured timestamps; flush beats push/pop.
module event_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [LVL_W-1:0] count;
    logic             do_pop;
    logic             do_push;

    // A push into a full FIFO is accepted only when a pop frees a slot on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign empty = (count == '0);
    assign full  = (count == LVL_W'(DEPTH));
    assign level = count;
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once count covers them.
    always_ff @(posedge clk) begin
        if (!flush && do_push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/match_event_logger.sv
// Timestamps sequence-detector matches into an event FIFO and keeps match/overflow stats.
module match_event_logger
    import match_event_pkg::*;
#(
    parameter int TS_WIDTH  = TS_WIDTH_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sequence_found,
    input  logic                         clear,
    match_event_logger_if.master         evt,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [CNT_WIDTH-1:0]         match_count,
    output logic                         overflow
);

    logic [TS_WIDTH-1:0] ts;
    logic [TS_WIDTH-1:0] head;
    logic                fifo_empty;
    logic                fifo_full;
    logic                pop_fire;

    assign pop_fire      = evt.evt_ready && !fifo_empty;
    assign evt.evt_valid = !fifo_empty;
    assign evt.evt_ts    = head;

    event_fifo #(
        .WIDTH (TS_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (clear),
        .push      (sequence_found),
        .pop       (evt.evt_ready),
        .push_data (ts),
        .head      (head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (level)
    );

    // Dropped matches still count; overflow only when no pop makes room on that edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts          <= '0;
            match_count <= '0;
            overflow    <= 1'b0;
        end else if (clear) begin
            ts          <= '0;
            match_count <= '0;
            overflow    <= 1'b0;
        end else begin
            ts <= ts + TS_WIDTH'(1);
            if (sequence_found) begin
                if (match_count != '1)
                    match_count <= match_count + CNT_WIDTH'(1);
                if (fifo_full && !pop_fire)
                    overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_match_event_logger.sv
// Randomized and directed bench comparing the logger against a queue-based model.
module tb_match_event_logger;

    localparam int TS_WIDTH  = 16;
    localparam int DEPTH     = 4;
    localparam int CNT_WIDTH = 8;
    localparam int TS_MOD    = 1 << TS_WIDTH;
    localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

    logic                         clk;
    logic                         reset;
    logic                         sequence_found;
    logic                         clear;
    logic [$clog2(DEPTH+1)-1:0]   level;
    logic [CNT_WIDTH-1:0]         match_count;
    logic                         overflow;

    match_event_logger_if #(.TS_WIDTH(TS_WIDTH)) evt_bus ();

    match_event_logger #(
        .TS_WIDTH  (TS_WIDTH),
        .DEPTH     (DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sequence_found (sequence_found),
        .clear          (clear),
        .evt            (evt_bus),
        .level          (level),
        .match_count    (match_count),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_compared;
    int          n_mismatched;
    int          m_ts;
    int          m_cnt;
    bit          m_ovf;
    int unsigned m_q [$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_q.delete();
        m_ts  = 0;
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    // Pop first so a full FIFO with a coincident pop still has room for the new event.
    task automatic modelStep(input bit sf, input bit rdy, input bit clr);
        if (clr) begin
            modelReset();
        end else begin
            if (rdy && m_q.size() > 0)
                void'(m_q.pop_front());
            if (sf) begin
                if (m_cnt < CNT_MAX)
                    m_cnt++;
                if (m_q.size() < DEPTH)
                    m_q.push_back(m_ts);
                else
                    m_ovf = 1'b1;
            end
            m_ts = (m_ts + 1) % TS_MOD;
        end
    endtask

    task automatic checkAll();
        checkOutput("evt_valid", 32'(evt_bus.evt_valid), 32'(m_q.size() != 0));
        checkOutput("level", 32'(level), 32'(m_q.size()));
        checkOutput("match_count", 32'(match_count), 32'(m_cnt));
        checkOutput("overflow", 32'(overflow), 32'(m_ovf));
        if (m_q.size() > 0)
            checkOutput("evt_ts", 32'(evt_bus.evt_ts), 32'(m_q[0]));
    endtask

    // Called just after a falling edge: drive, take one rising edge, check at the next falling edge.
    task automatic applyStimulus(input bit sf, input bit rdy, input bit clr);
        sequence_found    = sf;
        evt_bus.evt_ready = rdy;
        clear             = clr;
        @(posedge clk);
        modelStep(sf, rdy, clr);
        @(negedge clk);
        checkAll();
    endtask

    initial begin
        int guard;
        n_compared        = 0;
        n_mismatched      = 0;
        reset             = 1'b1;
        sequence_found    = 1'b0;
        clear             = 1'b0;
        evt_bus.evt_ready = 1'b0;
        modelReset();

        #1;
        checkOutput("reset_valid", 32'(evt_bus.evt_valid), 32'd0);
        checkOutput("reset_level", 32'(level), 32'd0);
        checkOutput("reset_count", 32'(match_count), 32'd0);
        checkOutput("reset_ovf", 32'(overflow), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Single pulse on the edge where ts=5.
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("pulse5_ts", 32'(evt_bus.evt_ts), 32'd5);
        checkOutput("pulse5_level", 32'(level), 32'd1);
        checkOutput("pulse5_count", 32'(match_count), 32'd1);

        // Five pulses at ts=2..6 into a 4-deep FIFO, then drain.
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("fill_level", 32'(level), 32'd4);
        checkOutput("fill_ovf", 32'(overflow), 32'd1);
        checkOutput("fill_count", 32'(match_count), 32'd5);
        for (int k = 0; k < 4; k++) begin
            checkOutput("drain_ts", 32'(evt_bus.evt_ts), 32'(2 + k));
            applyStimulus(1'b0, 1'b1, 1'b0);
        end
        checkOutput("drain_valid", 32'(evt_bus.evt_valid), 32'd0);

        // Push and pop together on a full FIFO.
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("fullpp_level", 32'(level), 32'd4);
        checkOutput("fullpp_ovf", 32'(overflow), 32'd0);
        checkOutput("fullpp_head", 32'(evt_bus.evt_ts), 32'd1);
        for (int k = 0; k < 4; k++) begin
            checkOutput("fullpp_order", 32'(evt_bus.evt_ts), 32'(1 + k));
            applyStimulus(1'b0, 1'b1, 1'b0);
        end

        // Match counter saturation.
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (300) applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("sat_count", 32'(match_count), 32'd255);
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("sat_hold", 32'(match_count), 32'd255);

        // Clear wins over a coincident match with level=3 and overflow set.
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("preclr_level", 32'(level), 32'd3);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("clr_level", 32'(level), 32'd0);
        checkOutput("clr_count", 32'(match_count), 32'd0);
        checkOutput("clr_ovf", 32'(overflow), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("clr_ts", 32'(evt_bus.evt_ts), 32'd0);

        // Asynchronous reset between edges with two stored events.
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_valid", 32'(evt_bus.evt_valid), 32'd0);
        checkOutput("async_level", 32'(level), 32'd0);
        modelReset();
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("async_ts0", 32'(evt_bus.evt_ts), 32'd0);

        // Randomized traffic with changing consumer throttling and rare clears.
        for (int i = 0; i < 2000; i++) begin
            int rdy_bias;
            rdy_bias = (i / 200) % 4;
            applyStimulus(($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 3) < rdy_bias),
                          ($urandom_range(0, 63) == 0));
        end

        // Run the timestamp to its wrap point and capture the wrapped value.
        guard = 0;
        while (m_ts != TS_MOD - 1 && guard < 70000) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            guard++;
        end
        checkOutput("wrap_reached", 32'(m_ts), 32'(TS_MOD - 1));
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("wrap_ts", 32'(evt_bus.evt_ts), 32'd0);
        checkOutput("wrap_valid", 32'(evt_bus.evt_valid), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
